// File: rtl/timer_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter_bank_if
// Brief    : Shared byte-wise write port into the timer/counter bank.
// Revision : 1.0 - initial release
// ============================================================================
interface timer_counter_bank_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int c_CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_BYTE_W = ((WIDTH / 8) > 1) ? $clog2(WIDTH / 8) : 1;

    logic                WR_EN;
    logic [c_CH_W-1:0]   WR_CH;
    logic [c_BYTE_W-1:0] WR_BYTE;
    logic                WR_SEL;
    logic [7:0]          WR_DATA;

    modport master (
        output WR_EN, WR_CH, WR_BYTE, WR_SEL, WR_DATA
    );

    modport slave (
        input  WR_EN, WR_CH, WR_BYTE, WR_SEL, WR_DATA
    );
endinterface
`default_nettype wire

// File: rtl/timer_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : timer_counter_bank
// Brief    : Multi-channel up/down timer/counter with auto-reload, tick and
//            sticky terminal-event flag; byte-wise CPU-loaded registers.
// Revision : 1.0 - initial release
// ============================================================================
module timer_counter_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      CLK,
    input  logic                      CPU_Reset,
    timer_counter_bank_if.slave       wr,
    input  logic [CHANNELS-1:0]       CH_EN,
    input  logic [CHANNELS-1:0]       CH_MODE,
    input  logic [CHANNELS-1:0]       CH_AUTORELOAD,
    input  logic [CHANNELS-1:0]       EVT_CLR,
    output logic [CHANNELS-1:0]       TIMER_TICK,
    output logic [CHANNELS-1:0]       TIMER_OV,
    output logic [CHANNELS*WIDTH-1:0] COUNT_OUT
);
    localparam int               c_LANES    = WIDTH / 8;
    localparam int               c_CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int               c_BYTE_W   = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_reload;
        logic             r_tick;
        logic             r_ov;
        logic [WIDTH-1:0] w_count_wr;
        logic [WIDTH-1:0] w_reload_wr;
        logic [WIDTH-1:0] w_step;
        logic             w_ch_hit;
        logic             w_cnt_write;
        logic             w_evt;
        logic             w_fire;

        // Channels outside the encodable range never match, so such writes drop out.
        assign w_ch_hit = wr.WR_EN && (wr.WR_CH == c_CH_W'(n));

        always_comb begin
            w_count_wr  = r_count;
            w_reload_wr = r_reload;
            w_cnt_write = 1'b0;
            for (int b = 0; b < c_LANES; b++) begin
                if (w_ch_hit && (wr.WR_BYTE == c_BYTE_W'(b))) begin
                    if (wr.WR_SEL) begin
                        w_reload_wr[b*8 +: 8] = wr.WR_DATA;
                    end else begin
                        w_count_wr[b*8 +: 8] = wr.WR_DATA;
                        w_cnt_write          = 1'b1;
                    end
                end
            end
        end

        always_comb begin
            w_step = r_count;
            w_evt  = 1'b0;
            if (CH_MODE[n]) begin
                if (r_count == c_ALL_ONES) begin
                    w_evt  = 1'b1;
                    w_step = CH_AUTORELOAD[n] ? r_reload : '0;
                end else begin
                    w_step = r_count + c_ONE;
                end
            end else begin
                if (r_count > c_ONE) begin
                    w_step = r_count - c_ONE;
                end else if (r_count == c_ONE) begin
                    w_step = '0;
                    w_evt  = 1'b1;
                end else begin
                    // Zero is the silent reload point, giving a period of reload+1.
                    w_step = CH_AUTORELOAD[n] ? r_reload : '0;
                end
            end
        end

        assign w_fire = !w_cnt_write && CH_EN[n] && w_evt;

        always_ff @(posedge CLK) begin
            if (CPU_Reset) begin
                r_count  <= '0;
                r_reload <= '0;
                r_tick   <= 1'b0;
                r_ov     <= 1'b0;
            end else begin
                r_reload <= w_reload_wr;
                r_tick   <= w_fire;
                if (w_cnt_write) begin
                    r_count <= w_count_wr;
                end else if (CH_EN[n]) begin
                    r_count <= w_step;
                end
                if (w_fire) begin
                    r_ov <= 1'b1;
                end else if (EVT_CLR[n]) begin
                    r_ov <= 1'b0;
                end
            end
        end

        assign COUNT_OUT[n*WIDTH +: WIDTH] = r_count;
        assign TIMER_TICK[n]               = r_tick;
        assign TIMER_OV[n]                 = r_ov;
    end
endmodule
`default_nettype wire

// File: tb/tb_timer_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_counter_bank
// Brief    : Scoreboard bench for two bank configurations (16x4 and 32x3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_counter_bank;
    logic CLK = 1'b0;
    logic CPU_Reset;
    always #5 CLK = ~CLK;

    logic [3:0]  a_en, a_mode, a_ar, a_clr, a_tick, a_ov;
    logic [63:0] a_cnt;
    logic [2:0]  b_en, b_mode, b_ar, b_clr, b_tick, b_ov;
    logic [95:0] b_cnt;

    timer_counter_bank_if #(.WIDTH(16), .CHANNELS(4)) ifa ();
    timer_counter_bank_if #(.WIDTH(32), .CHANNELS(3)) ifb ();

    timer_counter_bank #(.WIDTH(16), .CHANNELS(4)) dut_a (
        .CLK(CLK), .CPU_Reset(CPU_Reset), .wr(ifa),
        .CH_EN(a_en), .CH_MODE(a_mode), .CH_AUTORELOAD(a_ar), .EVT_CLR(a_clr),
        .TIMER_TICK(a_tick), .TIMER_OV(a_ov), .COUNT_OUT(a_cnt)
    );

    timer_counter_bank #(.WIDTH(32), .CHANNELS(3)) dut_b (
        .CLK(CLK), .CPU_Reset(CPU_Reset), .wr(ifb),
        .CH_EN(b_en), .CH_MODE(b_mode), .CH_AUTORELOAD(b_ar), .EVT_CLR(b_clr),
        .TIMER_TICK(b_tick), .TIMER_OV(b_ov), .COUNT_OUT(b_cnt)
    );

    typedef struct packed {
        logic [63:0] a_cnt;
        logic [3:0]  a_tk;
        logic [3:0]  a_ov;
        logic [95:0] b_cnt;
        logic [2:0]  b_tk;
        logic [2:0]  b_ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: [instance][channel], plain integers.
    longint unsigned m_cnt[2][4];
    longint unsigned m_rld[2][4];
    bit              m_tk[2][4];
    bit              m_ov[2][4];
    int              c_W[2]  = '{16, 32};
    int              c_NC[2] = '{4, 3};

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chan_step(input int w, inout longint unsigned cnt, inout longint unsigned rld,
                             inout bit tk, inout bit ov, input bit cwr, input bit rwr,
                             input int byt, input logic [7:0] d,
                             input bit en, input bit up, input bit ar, input bit clr);
        longint unsigned maxv = (64'd1 << w) - 1;
        longint unsigned mask = 64'hFF << (8 * byt);
        longint unsigned lane = 64'(d) << (8 * byt);
        longint unsigned nc   = cnt;
        bit              evt  = 0;
        if (cwr) begin
            nc = (cnt & ~mask) | lane;
        end else if (en) begin
            if (up) begin
                if (cnt == maxv) begin evt = 1; nc = ar ? rld : 0; end
                else nc = cnt + 1;
            end else begin
                if (cnt > 1) nc = cnt - 1;
                else if (cnt == 1) begin nc = 0; evt = 1; end
                else nc = ar ? rld : 0;
            end
        end
        if (rwr) rld = (rld & ~mask) | lane;
        cnt = nc;
        tk  = evt;
        if (evt) ov = 1;
        else if (clr) ov = 0;
    endtask

    task automatic model_cycle();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < c_NC[i]; n++) begin
                bit wen, sel, en, up, ar, clr, hit;
                int ch, byt;
                logic [7:0] d;
                if (i == 0) begin
                    wen = ifa.WR_EN; sel = ifa.WR_SEL; ch = int'(ifa.WR_CH); byt = int'(ifa.WR_BYTE);
                    d = ifa.WR_DATA; en = a_en[n]; up = a_mode[n]; ar = a_ar[n]; clr = a_clr[n];
                end else begin
                    wen = ifb.WR_EN; sel = ifb.WR_SEL; ch = int'(ifb.WR_CH); byt = int'(ifb.WR_BYTE);
                    d = ifb.WR_DATA; en = b_en[n]; up = b_mode[n]; ar = b_ar[n]; clr = b_clr[n];
                end
                hit = wen && (ch == n) && (byt < c_W[i] / 8);
                if (CPU_Reset) begin
                    m_cnt[i][n] = 0; m_rld[i][n] = 0; m_tk[i][n] = 0; m_ov[i][n] = 0;
                end else begin
                    chan_step(c_W[i], m_cnt[i][n], m_rld[i][n], m_tk[i][n], m_ov[i][n],
                              hit && !sel, hit && sel, byt, d, en, up, ar, clr);
                end
            end
        end
    endtask

    // Inputs change only at negedge; each step predicts the state after the next posedge.
    task automatic step();
        exp_t e;
        model_cycle();
        e = '0;
        for (int n = 0; n < 4; n++) begin
            e.a_cnt[n*16 +: 16] = 16'(m_cnt[0][n]);
            e.a_tk[n] = m_tk[0][n];
            e.a_ov[n] = m_ov[0][n];
        end
        for (int n = 0; n < 3; n++) begin
            e.b_cnt[n*32 +: 32] = 32'(m_cnt[1][n]);
            e.b_tk[n] = m_tk[1][n];
            e.b_ov[n] = m_ov[1][n];
        end
        sb.push_back(e);
        @(negedge CLK);
    endtask

    task automatic run(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    task automatic wr(input int inst, input int ch, input int byt, input bit sel, input logic [7:0] d);
        if (inst == 0) begin
            ifa.WR_EN = 1'b1; ifa.WR_CH = 2'(ch); ifa.WR_BYTE = 1'(byt); ifa.WR_SEL = sel; ifa.WR_DATA = d;
        end else begin
            ifb.WR_EN = 1'b1; ifb.WR_CH = 2'(ch); ifb.WR_BYTE = 2'(byt); ifb.WR_SEL = sel; ifb.WR_DATA = d;
        end
        step();
        ifa.WR_EN = 1'b0;
        ifb.WR_EN = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'h00;
            2:       return 8'($urandom_range(0, 3));
            default: return 8'($urandom);
        endcase
    endfunction

    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("a_count", 96'(a_cnt), 96'(e.a_cnt));
            chk("a_tick",  96'(a_tick), 96'(e.a_tk));
            chk("a_ov",    96'(a_ov), 96'(e.a_ov));
            chk("b_count", b_cnt, e.b_cnt);
            chk("b_tick",  96'(b_tick), 96'(e.b_tk));
            chk("b_ov",    96'(b_ov), 96'(e.b_ov));
        end
    end

    initial begin
        CPU_Reset = 1'b1;
        {a_en, a_mode, a_ar, a_clr} = '0;
        {b_en, b_mode, b_ar, b_clr} = '0;
        ifa.WR_EN = 0; ifa.WR_CH = '0; ifa.WR_BYTE = '0; ifa.WR_SEL = 0; ifa.WR_DATA = '0;
        ifb.WR_EN = 0; ifb.WR_CH = '0; ifb.WR_BYTE = '0; ifb.WR_SEL = 0; ifb.WR_DATA = '0;
        @(negedge CLK);
        a_en = 4'hF; b_en = 3'h7;
        run(2);
        CPU_Reset = 1'b0;
        run(10);

        // Channel 0: one-shot down from 3.
        b_en = '0;
        wr(0, 0, 0, 0, 8'h03);
        wr(0, 0, 1, 0, 8'h00);
        run(6);

        // Channel 1: down autoreload, period 5, with clear pulses.
        a_ar[1] = 1'b1;
        wr(0, 1, 0, 1, 8'h04);
        wr(0, 1, 1, 1, 8'h00);
        run(12);
        a_clr[1] = 1'b1; step(); a_clr[1] = 1'b0;
        run(6);
        a_clr[1] = 1'b1; run(12); a_clr[1] = 1'b0;

        // Channel 2: up through all-ones, with then without autoreload.
        a_en[2] = 1'b0; a_mode[2] = 1'b1; a_ar[2] = 1'b1;
        wr(0, 2, 0, 1, 8'h00);
        wr(0, 2, 1, 1, 8'h10);
        wr(0, 2, 0, 0, 8'hFE);
        wr(0, 2, 1, 0, 8'hFF);
        a_en[2] = 1'b1; run(3);
        a_en[2] = 1'b0; a_ar[2] = 1'b0;
        wr(0, 2, 0, 0, 8'hFE);
        wr(0, 2, 1, 0, 8'hFF);
        a_en[2] = 1'b1; run(3);

        // Channel 3: writes while running.
        a_en[3] = 1'b0;
        wr(0, 3, 0, 0, 8'h50);
        wr(0, 3, 1, 0, 8'h00);
        a_en[3] = 1'b1; run(3);
        wr(0, 3, 1, 0, 8'h12);
        run(3);
        wr(0, 3, 0, 1, 8'h77);
        wr(0, 3, 1, 1, 8'h01);
        run(3);

        // 32-bit bank: out-of-range channel, then full-width byte load.
        wr(1, 3, 0, 0, 8'hAA);
        wr(1, 2, 0, 0, 8'hEF);
        wr(1, 2, 1, 0, 8'hBE);
        wr(1, 2, 2, 0, 8'hAD);
        wr(1, 2, 3, 0, 8'hDE);
        chk("b_ch2_deadbeef", 96'(b_cnt[95:64]), 96'(32'hDEADBEEF));
        run(2);

        for (int k = 0; k < 800; k++) begin
            CPU_Reset = ($urandom_range(0, 99) == 0);
            a_en = 4'($urandom) | 4'($urandom); a_mode = 4'($urandom); a_ar = 4'($urandom);
            a_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            b_en = 3'($urandom) | 3'($urandom); b_mode = 3'($urandom); b_ar = 3'($urandom);
            b_clr = 3'($urandom) & 3'($urandom) & 3'($urandom);
            ifa.WR_EN = ($urandom_range(0, 2) == 0); ifa.WR_CH = 2'($urandom);
            ifa.WR_BYTE = 1'($urandom); ifa.WR_SEL = 1'($urandom); ifa.WR_DATA = rnd_byte();
            ifb.WR_EN = ($urandom_range(0, 2) == 0); ifb.WR_CH = 2'($urandom);
            ifb.WR_BYTE = 2'($urandom); ifb.WR_SEL = 1'($urandom); ifb.WR_DATA = rnd_byte();
            step();
        end
        CPU_Reset = 1'b0; ifa.WR_EN = 1'b0; ifb.WR_EN = 1'b0;
        run(4);

        @(posedge CLK);
        #2;
        chk("scoreboard_drained", 96'(sb.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
